// File: rtl/fmm_reduce_kernel_m_e_column_writer_if.sv
// ----------------------------------------------------------------------------
// fmm_reduce_kernel_m_e_column_writer_if
//   Bundles the ap_ctrl_hs job handshake, the job arguments and the M_e BRAM
//   write port of the column writer.
//   slave  : the column writer (takes start/args, drives done/idle/BRAM port)
//   master : the reduce-kernel control FSM side
//   Signals:
//     ap_start, rowt, col, pivot_row          master -> slave
//     ap_done, ap_idle, ap_ready               slave  -> master
//     M_e_address0, M_e_ce0, M_e_we0, M_e_d0   slave  -> BRAM
//     rows_written, rows_written_ap_vld        slave  -> master
// ----------------------------------------------------------------------------
interface fmm_reduce_kernel_m_e_column_writer_if #(
    parameter int ADDR_W = 17
);
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic signed [31:0] rowt;
    logic [ADDR_W-1:0] col;
    logic signed [31:0] pivot_row;
    logic [ADDR_W-1:0] M_e_address0;
    logic              M_e_ce0;
    logic              M_e_we0;
    logic [31:0]       M_e_d0;
    logic [31:0]       rows_written;
    logic              rows_written_ap_vld;

    modport slave (
        input  ap_start, rowt, col, pivot_row,
        output ap_done, ap_idle, ap_ready,
        output M_e_address0, M_e_ce0, M_e_we0, M_e_d0,
        output rows_written, rows_written_ap_vld
    );

    modport master (
        output ap_start, rowt, col, pivot_row,
        input  ap_done, ap_idle, ap_ready,
        input  M_e_address0, M_e_ce0, M_e_we0, M_e_d0,
        input  rows_written, rows_written_ap_vld
    );
endinterface

// File: rtl/fmm_reduce_kernel_m_e_column_writer.sv
// ----------------------------------------------------------------------------
// fmm_reduce_kernel_m_e_column_writer
//   Writes one column of the flattened M_e matrix (row stride 320 words):
//   the pivot row gets 1, every other visited row gets 0. One BRAM write per
//   cycle, ap_ctrl_hs-style start/done.
//   Ports:
//     ap_clk    clock, rising edge
//     ap_rst_n  asynchronous active-low reset
//     bus       job handshake + BRAM write port (slave modport)
//   Configuration macro:
//     FMM_M_E_WRITER_EARLY_STOP_EN - when defined, the column walk stops
//     right after the pivot row has been written.
// ----------------------------------------------------------------------------
module fmm_reduce_kernel_m_e_column_writer #(
    parameter int ADDR_W = 17
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    fmm_reduce_kernel_m_e_column_writer_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t             r_state;
    logic signed [31:0] r_rowt;
    logic signed [31:0] r_pivot;
    logic [ADDR_W-1:0]  r_col;
    logic [30:0]        r_row;      // row currently presented on the BRAM port
    logic [31:0]        r_cnt;      // writes completed before the current one
    logic               r_ce0;
    logic               r_we0;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_d0;
    logic               r_done;
    logic               r_idle;
    logic [31:0]        r_rows_written;

    logic [30:0]        w_row_nxt;
    logic [31:0]        w_rowt_m1;
    logic               w_last;

    // row*320 + col, built as (row<<8)+(row<<6)+col at 35 bits, then wrapped
    function automatic logic [ADDR_W-1:0] f_addr(input logic [30:0] row,
                                                 input logic [ADDR_W-1:0] c);
        logic [34:0] w_full;
        w_full = ({4'd0, row} << 8) + ({4'd0, row} << 6) + {{(35-ADDR_W){1'b0}}, c};
        return w_full[ADDR_W-1:0];
    endfunction

    // Row is non-negative, so a negative pivot (bit 31 set) never matches.
    function automatic logic f_hit(input logic [30:0] row, input logic [31:0] piv);
        return ({1'b0, row} == piv);
    endfunction

    assign w_row_nxt = r_row + 31'd1;
    assign w_rowt_m1 = $unsigned(r_rowt) - 32'd1;

`ifdef FMM_M_E_WRITER_EARLY_STOP_EN
    assign w_last = ({1'b0, r_row} == w_rowt_m1) || f_hit(r_row, $unsigned(r_pivot));
`else
    assign w_last = ({1'b0, r_row} == w_rowt_m1);
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state        <= S_IDLE;
            r_rowt         <= '0;
            r_pivot        <= '0;
            r_col          <= '0;
            r_row          <= '0;
            r_cnt          <= '0;
            r_ce0          <= 1'b0;
            r_we0          <= 1'b0;
            r_addr         <= '0;
            r_d0           <= '0;
            r_done         <= 1'b0;
            r_idle         <= 1'b1;
            r_rows_written <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        r_rowt  <= bus.rowt;
                        r_pivot <= bus.pivot_row;
                        r_col   <= bus.col;
                        r_row   <= '0;
                        r_cnt   <= '0;
                        r_idle  <= 1'b0;
                        if (bus.rowt > 32'sd0) begin
                            // Row 0 is presented in the first WRITE cycle.
                            r_state <= S_WRITE;
                            r_ce0   <= 1'b1;
                            r_we0   <= 1'b1;
                            r_addr  <= bus.col;
                            r_d0    <= {31'd0, (bus.pivot_row == 32'sd0)};
                        end else begin
                            r_state        <= S_DONE;
                            r_done         <= 1'b1;
                            r_rows_written <= '0;
                        end
                    end
                end
                S_WRITE: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_last) begin
                        r_state        <= S_DONE;
                        r_ce0          <= 1'b0;
                        r_we0          <= 1'b0;
                        r_addr         <= '0;
                        r_d0           <= '0;
                        r_done         <= 1'b1;
                        r_rows_written <= r_cnt + 32'd1;
                    end else begin
                        r_row  <= w_row_nxt;
                        r_addr <= f_addr(w_row_nxt, r_col);
                        r_d0   <= {31'd0, f_hit(w_row_nxt, $unsigned(r_pivot))};
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_idle  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.M_e_ce0             = r_ce0;
    assign bus.M_e_we0             = r_we0;
    assign bus.M_e_address0        = r_addr;
    assign bus.M_e_d0              = r_d0;
    assign bus.ap_done             = r_done;
    assign bus.ap_ready            = r_done;
    assign bus.rows_written_ap_vld = r_done;
    assign bus.ap_idle             = r_idle;
    assign bus.rows_written        = r_rows_written;

endmodule
